// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI link types and constants.
// State enum, clog2 helper, mode 0 constants.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    HOLD,
    GAP
  } spi_state_t;

  localparam bit CPOL = 1'b0;
  localparam bit CPHA = 1'b0;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// spi_tick_gen: sclk half-period counter.
// in: clk, reset, enable; out: tick (count==clk_div-1).
module spi_tick_gen
  import spi_pkg::*;
#(
  parameter int clk_div = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(clk_div - 1);

  logic [7:0] cnt;

  // held at zero while disabled so each frame starts phase-aligned
  always_ff @(posedge clk) begin
    if (reset || !enable) cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else cnt <= cnt + 8'd1;
  end

  assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/transmitter_spi.sv
// transmitter_spi: mode 0 MSB-first SPI frame sender.
// in: clk, reset, tx_data, tx_valid; out: tx_ready, sclk, cs, mosi, busy, done.
module transmitter_spi
  import spi_pkg::*;
#(
  parameter int width   = 32,
  parameter int clk_div = 4,
  parameter int cs_gap  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [width-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             sclk,
  output logic             cs,
  output logic             mosi,
  output logic             busy,
  output logic             done
);

  localparam int BW = (clog2(width) < 1) ? 1 : clog2(width);
  localparam logic [BW-1:0] LAST_BIT = BW'(width - 1);
  localparam logic [7:0] GAP_LAST =
    8'((cs_gap == 0) ? 0 : cs_gap - 1);

  spi_state_t       state, state_n;
  logic [width-1:0] sreg, sreg_n;
  logic [BW-1:0]    bit_cnt, bit_cnt_n;
  logic [7:0]       gap_cnt, gap_cnt_n;
  logic             tick, run, done_n;
  logic             frame_n;

  assign run = state inside {SHIFT_LO, SHIFT_HI, HOLD};

  spi_tick_gen #(
    .clk_div(clk_div)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .enable (run),
    .tick   (tick)
  );

  always_comb begin
    state_n   = state;
    sreg_n    = sreg;
    bit_cnt_n = bit_cnt;
    gap_cnt_n = gap_cnt;
    done_n    = 1'b0;
    unique case (state)
      IDLE:
        if (tx_valid && tx_ready) begin
          state_n   = SHIFT_LO;
          sreg_n    = tx_data;
          bit_cnt_n = '0;
        end
      SHIFT_LO:
        if (tick) state_n = SHIFT_HI;
      SHIFT_HI:
        if (tick) begin
          if (bit_cnt == LAST_BIT) begin
            state_n = HOLD;
          end else begin
            sreg_n    = sreg << 1;
            bit_cnt_n = bit_cnt + 1'b1;
            state_n   = SHIFT_LO;
          end
        end
      HOLD:
        if (tick) begin
          done_n    = 1'b1;
          bit_cnt_n = '0;
          gap_cnt_n = '0;
          state_n   = (cs_gap == 0) ? IDLE : GAP;
        end
      GAP:
        if (gap_cnt == GAP_LAST) begin
          gap_cnt_n = '0;
          state_n   = IDLE;
        end else begin
          gap_cnt_n = gap_cnt + 8'd1;
        end
      default: state_n = IDLE;
    endcase
  end

  assign frame_n = state_n inside {SHIFT_LO, SHIFT_HI, HOLD};

  // outputs are registered from the next state so the
  // link sees clean edges with no decode glitches
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sreg     <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      tx_ready <= 1'b0;
      sclk     <= CPOL;
      cs       <= 1'b1;
      mosi     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      sreg     <= sreg_n;
      bit_cnt  <= bit_cnt_n;
      gap_cnt  <= gap_cnt_n;
      tx_ready <= (state_n == IDLE);
      sclk     <= (state_n == SHIFT_HI) ^ CPOL;
      cs       <= !frame_n;
      mosi     <= frame_n ? sreg_n[width-1] : 1'b0;
      busy     <= (state_n != IDLE);
      done     <= done_n;
    end
  end

endmodule

// File: tb/tb_transmitter_spi.sv
// tb_transmitter_spi: scoreboard bench for transmitter_spi.
// Two instances: (8,2,2) and (32,1,0).
module tb_transmitter_spi;

  localparam int WA = 8;
  localparam int DIVA = 2;
  localparam int GAPA = 2;
  localparam int WB = 32;
  localparam int DIVB = 1;
  localparam int GAPB = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  logic          ra = 1'b1, va = 1'b0;
  logic [WA-1:0] da = '0;
  logic rdya, sclka, csa, mosia, busya, donea;

  logic          rb = 1'b1, vb = 1'b0;
  logic [WB-1:0] db = '0;
  logic rdyb, sclkb, csb, mosib, busyb, doneb;

  transmitter_spi #(
    .width(WA), .clk_div(DIVA), .cs_gap(GAPA)
  ) u_a (
    .clk(clk), .reset(ra), .tx_data(da), .tx_valid(va),
    .tx_ready(rdya), .sclk(sclka), .cs(csa),
    .mosi(mosia), .busy(busya), .done(donea)
  );

  transmitter_spi #(
    .width(WB), .clk_div(DIVB), .cs_gap(GAPB)
  ) u_b (
    .clk(clk), .reset(rb), .tx_data(db), .tx_valid(vb),
    .tx_ready(rdyb), .sclk(sclkb), .cs(csb),
    .mosi(mosib), .busy(busyb), .done(doneb)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // k = 1-based cycle index inside the cs-low window
  function automatic logic sclk_exp(int k, int div, int w);
    int ph;
    ph = (k - 1) / div;
    return (ph % 2 == 1) && (ph < 2 * w);
  endfunction

  logic [WA-1:0] qa[$];
  logic [WB-1:0] qb[$];
  int acca = 0, prev_acca = 0, accb = 0;
  int dna = 0, dnb = 0;

  // ---------------- monitor A ----------------
  logic [WA-1:0] rxa = '0;
  logic [WA-1:0] expa;
  int nba = 0, lowa = 0, lowlen_a = 0, gapa = 0;
  logic psa = 0, pma = 0, pca = 1, pba = 0, pda = 0;

  always @(negedge clk) begin
    if (ra) begin
      rxa = '0; nba = 0; lowa = 0; gapa = 0;
    end else begin
      if (!csa) begin
        lowa++;
        chk("a_sclk_pat", sclka, sclk_exp(lowa, DIVA, WA));
      end else begin
        chk("a_sclk_idle", sclka, 1'b0);
      end
      if (csa && !pca) begin
        lowlen_a = lowa;
        lowa = 0;
      end
      if (csa && busya) gapa++;
      if (!busya && pba) begin
        chk("a_gap_len", gapa, GAPA);
        gapa = 0;
      end
      if (sclka && !psa) begin
        chk("a_mosi_stable", mosia, pma);
        rxa = {rxa[WA-2:0], mosia};
        nba++;
      end
      if (donea) begin
        dna++;
        chk("a_done_pulse", pda, 1'b0);
        chk("a_sb_nonempty", qa.size() > 0, 1'b1);
        if (qa.size() > 0) begin
          expa = qa.pop_front();
          chk("a_word", rxa, expa);
        end
        chk("a_bits", nba, WA);
        chk("a_cs_low", lowlen_a, DIVA * (2 * WA + 1));
        chk("a_done_lat", cyc - acca + 1, DIVA * (2 * WA + 1) + 1);
        rxa = '0;
        nba = 0;
      end
    end
    psa = sclka; pma = mosia; pca = csa; pba = busya; pda = donea;
  end

  // ---------------- monitor B ----------------
  logic [WB-1:0] rxb = '0;
  logic [WB-1:0] expb;
  int nbb = 0, lowb = 0, lowlen_b = 0, gapb = 0;
  logic psb = 0, pmb = 0, pcb = 1, pbb = 0, pdb = 0;

  always @(negedge clk) begin
    if (rb) begin
      rxb = '0; nbb = 0; lowb = 0; gapb = 0;
    end else begin
      if (pdb) chk("b_rdy_after_done", rdyb, 1'b1);
      if (!csb) begin
        lowb++;
        chk("b_sclk_pat", sclkb, sclk_exp(lowb, DIVB, WB));
      end else begin
        chk("b_sclk_idle", sclkb, 1'b0);
      end
      if (csb && !pcb) begin
        lowlen_b = lowb;
        lowb = 0;
      end
      if (csb && busyb) gapb++;
      if (!busyb && pbb) begin
        chk("b_gap_len", gapb, GAPB);
        gapb = 0;
      end
      if (sclkb && !psb) begin
        chk("b_mosi_stable", mosib, pmb);
        rxb = {rxb[WB-2:0], mosib};
        nbb++;
      end
      if (doneb) begin
        dnb++;
        chk("b_done_pulse", pdb, 1'b0);
        chk("b_sb_nonempty", qb.size() > 0, 1'b1);
        if (qb.size() > 0) begin
          expb = qb.pop_front();
          chk("b_word", rxb, expb);
        end
        chk("b_bits", nbb, WB);
        chk("b_cs_low", lowlen_b, DIVB * (2 * WB + 1));
        chk("b_done_lat", cyc - accb + 1, DIVB * (2 * WB + 1) + 1);
        rxb = '0;
        nbb = 0;
      end
    end
    psb = sclkb; pmb = mosib; pcb = csb; pbb = busyb; pdb = doneb;
  end

  // ---------------- drivers ----------------
  task automatic send_a(input logic [WA-1:0] d, input bit keep);
    int n;
    n = 0;
    @(negedge clk);
    va = 1'b1;
    da = d;
    while (!rdya && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("a_accept_wait", rdya, 1'b1);
    if (rdya) begin
      qa.push_back(d);
      @(posedge clk);
      #1;
      prev_acca = acca;
      acca = cyc;
    end
    if (!keep) va = 1'b0;
  endtask

  task automatic send_b(input logic [WB-1:0] d);
    int n;
    n = 0;
    @(negedge clk);
    vb = 1'b1;
    db = d;
    while (!rdyb && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("b_accept_wait", rdyb, 1'b1);
    if (rdyb) begin
      qb.push_back(d);
      @(posedge clk);
      #1;
      accb = cyc;
    end
    vb = 1'b0;
  endtask

  task automatic idle_a();
    int n;
    n = 0;
    while ((qa.size() != 0 || !rdya) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("a_drain", qa.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic idle_b();
    int n;
    n = 0;
    while ((qb.size() != 0 || !rdyb) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("b_drain", qb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_rst_a(input string tag);
    chk({tag, "_cs"}, csa, 1'b1);
    chk({tag, "_sclk"}, sclka, 1'b0);
    chk({tag, "_mosi"}, mosia, 1'b0);
    chk({tag, "_done"}, donea, 1'b0);
    chk({tag, "_busy"}, busya, 1'b0);
    chk({tag, "_rdy"}, rdya, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  int d0;

  initial begin
    repeat (3) @(negedge clk);
    chk_rst_a("a_rst");
    chk("b_rst_cs", csb, 1'b1);
    chk("b_rst_rdy", rdyb, 1'b0);
    ra = 1'b0;
    rb = 1'b0;
    @(negedge clk);
    chk("a_rdy_post_rst", rdya, 1'b1);
    chk("b_rdy_post_rst", rdyb, 1'b1);

    // basic frame
    send_a(8'hA5, 1'b0);
    idle_a();

    // back-to-back with tx_valid held
    send_a(8'hFF, 1'b1);
    send_a(8'h00, 1'b0);
    chk("a_b2b_period", acca - prev_acca,
        DIVA * (2 * WA + 1) + GAPA + 1);
    idle_a();

    // reset during bit 3
    send_a(8'h3C, 1'b0);
    repeat (14) @(negedge clk);
    ra = 1'b1;
    @(negedge clk);
    chk_rst_a("a_mid_rst");
    qa.delete();
    @(negedge clk);
    ra = 1'b0;
    chk("a_rdy_rst_hold", rdya, 1'b0);
    @(negedge clk);
    chk("a_rdy_after_rst", rdya, 1'b1);
    send_a(8'hC3, 1'b0);
    idle_a();

    // handshake ignored while busy
    d0 = dna;
    send_a(8'h22, 1'b0);
    repeat (4) @(negedge clk);
    va = 1'b1;
    da = 8'h11;
    chk("a_rdy_busy", rdya, 1'b0);
    @(negedge clk);
    va = 1'b0;
    idle_a();
    chk("a_one_done", dna - d0, 1);

    for (int i = 0; i < 3; i++) begin
      send_a(WA'($urandom), 1'b0);
      idle_a();
    end

    // clk_div=1, no gap
    send_b(32'h8000_0001);
    idle_b();
    for (int i = 0; i < 2; i++) begin
      send_b($urandom);
      idle_b();
    end
    chk("b_done_count", dnb, 3);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
